// File: rtl/uart_rx_gen.sv
// uart_rx_gen: runtime-configurable oversampling UART receiver with a one-word valid/ready holding register.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned OVS    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_line,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_frame_err,
    output logic              m_parity_err,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic              busy
);
    localparam int unsigned TW = $clog2(OVS);
    localparam logic [TW-1:0] LAST_C = TW'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] SAMPLE_C = TW'(OVS / 2);
`else
    localparam logic [TW-1:0] SAMPLE_C = TW'(OVS / 2 - 1);
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;

    logic              sync1, rxs, rxs_prev;
    logic [DIV_W-1:0]  div_q, pre_cnt;
    logic [3:0]        nbits_q, nbits_clamped, idx;
    logic              par_en_q, par_odd_q, two_q;
    logic              tick;
    logic [TW-1:0]     tick_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_acc, frame_err_q, par_err_q;
    logic              start_edge, sample_pt, bit_end, bit_val, complete, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= rx_line;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s_a, s_b;
    // Two previous tick samples plus the live value form the 2-of-3 vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else if (tick) begin
            s_a <= s_b;
            s_b <= rxs;
        end
    end
    assign bit_val = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
`else
    assign bit_val = rxs;
`endif

    always_comb begin
        nbits_clamped = data_bits;
        if (data_bits < 4'd5)
            nbits_clamped = 4'd5;
        else if (data_bits > 4'(DATA_W))
            nbits_clamped = 4'(DATA_W);
    end

    assign start_edge = (state == IDLE) && rxs_prev && !rxs;
    assign sample_pt  = tick && (tick_cnt == SAMPLE_C);
    assign bit_end    = tick && (tick_cnt == LAST_C);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        complete = 1'b0;
        case (state)
            IDLE:   if (start_edge) state_nx = START;
            START: begin
                if (sample_pt && bit_val)
                    state_nx = IDLE;
                else if (bit_end)
                    state_nx = DATA;
            end
            DATA:   if (bit_end && idx == nbits_q - 4'd1) state_nx = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) state_nx = STOP;
            STOP: begin
                if (sample_pt && idx == {3'b000, two_q}) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The tick is registered so the first tick lands exactly T clocks after START entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            pre_cnt     <= '0;
            nbits_q     <= 4'd8;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_q       <= 1'b0;
            tick        <= 1'b0;
            tick_cnt    <= '0;
            idx         <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else if (state == IDLE) begin
            pre_cnt  <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
            idx      <= '0;
            if (start_edge) begin
                div_q       <= baud_div;
                nbits_q     <= nbits_clamped;
                par_en_q    <= ^parity_mode;
                par_odd_q   <= (parity_mode == 2'b10);
                two_q       <= two_stop;
                shreg       <= '0;
                par_acc     <= 1'b0;
                frame_err_q <= 1'b0;
                par_err_q   <= 1'b0;
            end
        end else begin
            tick    <= (pre_cnt == div_q);
            pre_cnt <= (pre_cnt == div_q) ? '0 : pre_cnt + DIV_W'(1);
            if (tick)
                tick_cnt <= tick_cnt + TW'(1);
            if (state_nx != state)
                idx <= '0;
            else if (bit_end)
                idx <= idx + 4'd1;
            if (sample_pt) begin
                case (state)
                    DATA: begin
                        for (int unsigned i = 0; i < DATA_W; i++)
                            if (i == 32'(idx))
                                shreg[i] <= bit_val;
                        par_acc <= par_acc ^ bit_val;
                    end
                    PARITY:  par_err_q <= bit_val ^ par_acc ^ par_odd_q;
                    STOP:    if (!bit_val) frame_err_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign load = complete && (!m_valid || m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_frame_err  <= 1'b0;
            m_parity_err <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load) begin
                m_data       <= shreg;
                m_valid      <= 1'b1;
                m_frame_err  <= frame_err_q | ~bit_val;
                m_parity_err <= par_err_q;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (complete && !load)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_gen.sv
// Scoreboard bench for uart_rx_gen: a frame-level reference model queues expected words, a monitor checks deliveries.
module tb_uart_rx_gen;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned OVS    = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_line = 1'b1;
    logic [DIV_W-1:0]  baud_div = 16'd3;
    logic [3:0]        data_bits = 4'd8;
    logic [1:0]        parity_mode = 2'b00;
    logic              two_stop = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              m_frame_err;
    logic              m_parity_err;
    logic              overrun;
    logic              clr_overrun = 1'b0;
    logic              busy;

    uart_rx_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W), .OVS(OVS)) dut (
        .clk(clk), .rst_n(rst_n), .rx_line(rx_line), .baud_div(baud_div),
        .data_bits(data_bits), .parity_mode(parity_mode), .two_stop(two_stop),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_frame_err(m_frame_err), .m_parity_err(m_parity_err),
        .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              fe;
        logic              pe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   exp_lat = 0;
    logic busy_d = 1'b0;
    logic valid_d = 1'b0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(m_data), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("m_data", 32'(m_data), 32'(mon_e.data));
                check("m_frame_err", 32'(m_frame_err), 32'(mon_e.fe));
                check("m_parity_err", 32'(m_parity_err), 32'(mon_e.pe));
            end
        end
    end

    always @(negedge clk) begin
        if (busy && !busy_d)
            t0 = cyc;
        if (rst_n && m_valid && !valid_d)
            check("valid_latency", cyc - t0, exp_lat);
        busy_d  = busy;
        valid_d = m_valid;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    // Frame-level reference model: builds the line bit sequence and the expected word/flags/latency.
    task automatic send(input logic [8:0] data, input int nb_req, input logic [1:0] pm,
                        input logic ts, input int div, input bit bad_par, input int bad_stop,
                        input int spike_bit, input bit push, input int gap, input bit scramble);
        int         n, nstop, bper;
        logic       par_en, odd;
        logic [8:0] md;
        logic       fr[$];
        n      = (nb_req < 5) ? 5 : ((nb_req > int'(DATA_W)) ? int'(DATA_W) : nb_req);
        par_en = (pm == 2'b01) || (pm == 2'b10);
        odd    = (pm == 2'b10);
        nstop  = ts ? 2 : 1;
        bper   = int'(OVS) * (div + 1);
        md     = data & ((9'd1 << n) - 9'd1);
        baud_div    = DIV_W'(div);
        data_bits   = 4'(nb_req);
        parity_mode = pm;
        two_stop    = ts;
        fr.push_back(1'b0);
        for (int i = 0; i < n; i++) fr.push_back(md[i]);
        if (par_en) fr.push_back((^md) ^ odd ^ bad_par);
        for (int s = 0; s < nstop; s++) fr.push_back(bad_stop == s ? 1'b0 : 1'b1);
        exp_lat = (n + (par_en ? 1 : 0) + nstop) * bper + (int'(OVS) / 2) * (div + 1) + 1 + MAJ * (div + 1);
        if (push) exp_q.push_back('{md[DATA_W-1:0], bad_stop >= 0, par_en && bad_par});
        foreach (fr[j]) begin
            for (int i = 0; i < bper; i++) begin
                @(posedge clk); #1;
                rx_line = (j == spike_bit && i == (int'(OVS) / 2) * (div + 1) + 1) ? ~fr[j] : fr[j];
                if (scramble && j == 2 && i == 0) begin
                    baud_div    = DIV_W'($urandom_range(0, 9));
                    data_bits   = 4'($urandom_range(0, 15));
                    parity_mode = 2'($urandom_range(0, 3));
                    two_stop    = 1'($urandom_range(0, 1));
                end
                if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
            end
        end
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            rx_line = 1'b1;
            if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_m_data"}, 32'(m_data), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_frame_err"}, 32'(m_frame_err), 0);
        check({tag, "_m_parity_err"}, 32'(m_parity_err), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int   nb, div, bs, wait_cnt;
        logic ts;
        logic [1:0] pm;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        send(9'hA5, 8, 2'b00, 1'b0, 3, 1'b0, -1, -1, 1'b1, 128, 1'b0);
        check("overrun_after_a5", 32'(overrun), 0);

        send(9'h35, 7, 2'b01, 1'b1, 3, 1'b1, -1, -1, 1'b1, 128, 1'b0);

        send(9'h3C, 8, 2'b00, 1'b0, 3, 1'b0, 0, -1, 1'b1, 128, 1'b0);
        send(9'h81, 8, 2'b00, 1'b0, 3, 1'b0, -1, -1, 1'b1, 128, 1'b0);

        // 20-clock low glitch on an idle line
        @(posedge clk); #1 rx_line = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_rises", 32'(busy), 1);
        repeat (10) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_idle", 32'(busy), 0);
        check("glitch_no_valid", 32'(m_valid), 0);

`ifdef UART_RX_MAJORITY_EN
        send(9'h4B, 8, 2'b00, 1'b0, 3, 1'b0, -1, 3, 1'b1, 128, 1'b0);
`endif

        // Overrun: hold off the consumer across two back-to-back frames
        @(posedge clk); #1 m_ready = 1'b0;
        send(9'h11, 8, 2'b00, 1'b0, 3, 1'b0, -1, -1, 1'b1, 0, 1'b0);
        send(9'h22, 8, 2'b00, 1'b0, 3, 1'b0, -1, -1, 1'b0, 128, 1'b0);
        @(negedge clk);
        check("ovr_held_valid", 32'(m_valid), 1);
        check("ovr_held_data", 32'(m_data), 32'h11);
        check("ovr_flag_set", 32'(overrun), 1);
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("ovr_valid_dropped", 32'(m_valid), 0);
        check("ovr_queue_drained", exp_q.size(), 0);
        check("ovr_flag_sticky", 32'(overrun), 1);
        @(posedge clk); #1 clr_overrun = 1'b1;
        @(posedge clk); #1 clr_overrun = 1'b0;
        @(negedge clk);
        check("ovr_flag_cleared", 32'(overrun), 0);

        // Reset mid-frame with a word (carrying a parity error) held
        send(9'hC3, 8, 2'b10, 1'b0, 3, 1'b1, -1, -1, 1'b1, 64, 1'b0);
        @(negedge clk);
        check("rst_pre_valid", 32'(m_valid), 1);
        check("rst_pre_parity_err", 32'(m_parity_err), 1);
        for (int i = 0; i < 64; i++) begin @(posedge clk); #1 rx_line = 1'b0; end
        for (int i = 0; i < 32; i++) begin @(posedge clk); #1 rx_line = 1'b1; end
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 1);
        @(posedge clk); #1;
        rst_n   = 1'b0;
        rx_line = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("midframe_rst");
        m_ready = 1'b1;
        send(9'h5A, 8, 2'b00, 1'b0, 3, 1'b0, -1, -1, 1'b1, 128, 1'b0);

        // Randomised frames with random consumer stalls and mid-frame config changes
        rand_rdy = 1'b1;
        repeat (24) begin
            nb  = $urandom_range(3, 10);
            pm  = 2'($urandom_range(0, 3));
            ts  = 1'($urandom_range(0, 1));
            div = $urandom_range(0, 3);
            bs  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ts ? 1 : 0) : -1;
            send(9'($urandom_range(0, 511)), nb, pm, ts, div, ($urandom_range(0, 3) == 0), bs, -1,
                 1'b1, 2 * int'(OVS) * (div + 1) + $urandom_range(0, 20), 1'b1);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1 m_ready = 1'b1;

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("final_queue_empty", exp_q.size(), 0);
        check("final_overrun", 32'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_gen.md
# uart_rx_gen

Parametrised, runtime-configurable UART receiver, the next generation of the fixed 8-bit `RX` block. It adds a programmable data width, parity, stop-bit count and oversampled baud divisor, plus framing/parity/overrun detection and a valid/ready output with a one-word holding register. It sits between the `rx` pin and the RX FIFO (`Fifo_UART`), on the 60 MHz PLL clock domain.

## Interface
- `DATA_W`, 8: maximum data bits per frame (5..9); `m_data` width.
- `DIV_W`, 16: width of `baud_div`.
- `OVS`, 16: oversample ticks per bit; must be a power of two, ≥8.
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_line`  in  1  serial input, asynchronous; idles high.
- `baud_div`  in  DIV_W  oversample tick period = `baud_div`+1 clocks.
- `data_bits`  in  4  bits per frame (5..DATA_W); values outside this range are clamped.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `two_stop`  in  1  0: one stop bit, 1: two stop bits.
- `m_data`  out  DATA_W  received word, LSB-aligned, upper bits zero.
- `m_valid`  out  1  word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_frame_err`  out  1  stop bit sampled low; qualified by `m_valid`.
- `m_parity_err`  out  1  parity mismatch; qualified by `m_valid`.
- `overrun`  out  1  sticky; a word was dropped because the holding register was full.
- `clr_overrun`  in  1  single-cycle pulse that clears `overrun`.
- `busy`  out  1  frame reception in progress (state ≠ IDLE).

## Operation
- `rx_line` passes through a 2-flop synchroniser; all logic uses the synchronised value `rxs`.
- Prescaler: counts 0..`baud_div`, emits `tick` at the terminal count. It is cleared on entry to START.
- Bit counter: counts ticks 0..OVS-1 within each bit. The sample point is tick OVS/2.
- States:
  - IDLE: a falling edge on `rxs` (previous sample 1, current sample 0) → START. `baud_div`, `data_bits`, `parity_mode` and `two_stop` are latched at this point and stay frozen for the whole frame.
  - START: at the sample point, `rxs`=1 is a false start → IDLE; otherwise → DATA at the end of the bit.
  - DATA: samples bits LSB first, `data_bits` of them. → PARITY if parity is enabled, else → STOP.
  - PARITY: compares the sampled bit against the XOR of the data bits (even) or its inverse (odd), and records a mismatch.
  - STOP: samples each stop bit; any low sample sets the frame error. At the sample point of the last stop bit the frame completes → IDLE, so the receiver is ready for a back-to-back start edge.
- Frame completion:
  - If `m_valid`=0, or the current word is being accepted this cycle (`m_valid`&`m_ready`): load `m_data` and both error flags, and set `m_valid`.
  - Otherwise: discard the new word, keep the held one, and set `overrun`.
- Words with errors are still delivered; the error flags describe that word.
- `clr_overrun` and a new overrun in the same cycle: `overrun` stays 1 (set wins).

## Timing
- Reset values: `m_data`=0, `m_valid`=0, `m_frame_err`=0, `m_parity_err`=0, `overrun`=0, `busy`=0. The synchroniser resets to 1 (idle).
- Define T = `baud_div`+1 and B = OVS·T clocks per bit. The falling edge is seen in IDLE 2 cycles after the pin changes (synchroniser).
- Data bit k is sampled at (k+1)·B + (OVS/2)·T clocks after START entry (±1).
- `m_valid` rises 1 cycle after the last stop-bit sample point. For 8N1 this is 9·B + (OVS/2)·T + 1 clocks after START entry.
- `m_valid` holds until the cycle in which `m_ready`=1. It deasserts the next cycle unless a new word is loaded in that same cycle.
- Changing the configuration inputs mid-frame has no effect until the next start edge.
- Asserting `rst_n` low mid-frame aborts the frame immediately. No partial word is ever presented.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit (start, data, parity, stop) takes the 2-of-3 majority of the samples at ticks OVS/2-1, OVS/2 and OVS/2+1. The decision is made at tick OVS/2+1, so all sample points move one tick (T clocks) later.
- Not defined: a single sample at tick OVS/2. No extra sample registers are instantiated.

## Test plan
- 8N1, `baud_div`=3 (B=64), send 0xA5 → one `m_valid` with `m_data`=0xA5, both error flags 0, `overrun` 0. Check `m_valid` timing against the formula above.
- 7E2 with `data_bits`=7, `parity_mode`=01, send 0x35 with a deliberately wrong parity bit → `m_data`=0x35, `m_parity_err`=1, `m_frame_err`=0.
- 8N1, send 0x3C with the stop bit driven low → `m_data`=0x3C, `m_frame_err`=1. The receiver then accepts a following 0x81 correctly.
- Low glitch of 20 clocks on an idle line (B=64) → false start, no `m_valid`, `busy` returns to 0. With `UART_RX_MAJORITY_EN` defined, a single-clock spike inside a data bit does not flip that bit.
- `m_ready` held 0, send 0x11 then 0x22 back-to-back → `m_data` stays 0x11 and `overrun`=1. Pulsing `m_ready` then delivers 0x11 and nothing else. `clr_overrun` clears the flag.
- Assert `rst_n` low for 3 cycles in the middle of DATA → all outputs return to their reset values. The next frame, 0x5A, is received correctly.
